// File: rtl/i2c_rx_if.sv
// Host strobes and observed I2C bus lines for the receive-side monitor i2c_rx.
// master: the side that drives the bus and start strobes. slave: the i2c_rx block.
interface i2c_rx_if;
    logic       start_i;
    logic       rxread_i;
    logic       scl_i;
    logic       sda_i;
    logic       sda_sel_i;
    logic [7:0] rdata_o;
    logic [2:0] ack_o;
    logic       nack_o;
    logic       done_o;
    logic       busy_o;

    modport master (
        output start_i, rxread_i, scl_i, sda_i, sda_sel_i,
        input  rdata_o, ack_o, nack_o, done_o, busy_o
    );

    modport slave (
        input  start_i, rxread_i, scl_i, sda_i, sda_sel_i,
        output rdata_o, ack_o, nack_o, done_o, busy_o
    );
endinterface

// File: rtl/i2c_rx.sv
// I2C receive monitor: captures slave ACK bits and the read byte behind the master transmitter.
// Optional watchdog enabled by defining RX_TIMEOUT_EN (adds timeout_o).
module i2c_rx #(
    parameter int SAMPLE_DLY  = 30,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic clk_i,
    input  logic rst_i,
`ifdef RX_TIMEOUT_EN
    output logic timeout_o,
`endif
    i2c_rx_if.slave bus
);
    localparam int CNT_W = $clog2(SAMPLE_DLY + 2);
    localparam logic [CNT_W-1:0] DLY_C = CNT_W'(SAMPLE_DLY);
`ifdef RX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 2);
    localparam logic [WD_W-1:0] TO_C = WD_W'(TIMEOUT_CYC);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_RISE, ST_SAMPLE, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic             scl_s1_q, scl_s2_q, scl_prev_q;
    logic             sda_s1_q, sda_s2_q;
    logic             rd_mode_q, rd_mode_d;
    logic [3:0]       bitn_q, bitn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       acc_q, acc_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [2:0]       ack_q, ack_d;
    logic             nack_q, nack_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef RX_TIMEOUT_EN
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             timeout_q, timeout_d;
`endif

    logic       scl_rise;
    logic       owned;
    logic       end_hit;
    logic [2:0] acc_nx;
    logic [7:0] shift_nx;

    // Synchronisers idle at 1 so a released bus never looks like an edge after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
        end else begin
            scl_s1_q   <= bus.scl_i;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= bus.sda_i;
            sda_s2_q   <= sda_s1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_mode_d = rd_mode_q;
        bitn_d    = bitn_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        ack_d     = ack_q;
        nack_d    = nack_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        end_hit   = 1'b0;
        acc_nx    = acc_q;
        shift_nx  = shift_q;
        scl_rise  = scl_s2_q & ~scl_prev_q;
        owned     = (state_q == ST_SAMPLE) && scl_s2_q && (cnt_q == DLY_C) && bus.sda_sel_i;
`ifdef RX_TIMEOUT_EN
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    rd_mode_d = bus.rxread_i;
                    bitn_d    = 4'd0;
                    acc_d     = 3'b000;
                    shift_d   = 8'h00;
                    busy_d    = 1'b1;
                    state_d   = ST_WAIT_RISE;
`ifdef RX_TIMEOUT_EN
                    wdog_d    = '0;
`endif
                end
            end
            ST_WAIT_RISE: begin
                if (scl_rise) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (!scl_s2_q) begin
                    // SCL fell before the sample point: treat the pulse as a glitch.
                    state_d = ST_WAIT_RISE;
                end else if (cnt_q == DLY_C) begin
                    state_d = ST_WAIT_RISE;
                    if (owned) begin
                        if (bitn_q < 4'd3) acc_nx[bitn_q[1:0]] = ~sda_s2_q;
                        else if (rd_mode_q) shift_nx = {shift_q[6:0], sda_s2_q};
                        acc_d   = acc_nx;
                        shift_d = shift_nx;
                        bitn_d  = bitn_q + 4'd1;
                        end_hit = rd_mode_q ? (bitn_q == 4'd10) : (bitn_q == 4'd2);
                    end
                    if (end_hit) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        ack_d   = acc_nx;
                        nack_d  = ~&acc_nx;
                        if (rd_mode_q) rdata_d = shift_nx;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef RX_TIMEOUT_EN
        // Watchdog runs only while waiting on the slave; an owned sample restarts it.
        if (state_q == ST_WAIT_RISE || state_q == ST_SAMPLE) begin
            if (owned) begin
                wdog_d = '0;
            end else if (wdog_q == TO_C) begin
                state_d   = ST_DONE;
                done_d    = 1'b1;
                timeout_d = 1'b1;
                nack_d    = 1'b1;
                ack_d     = acc_q;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rd_mode_q <= 1'b0;
            bitn_q    <= 4'd0;
            cnt_q     <= '0;
            acc_q     <= 3'b000;
            shift_q   <= 8'h00;
            rdata_q   <= 8'h00;
            ack_q     <= 3'b000;
            nack_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef RX_TIMEOUT_EN
            wdog_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rd_mode_q <= rd_mode_d;
            bitn_q    <= bitn_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef RX_TIMEOUT_EN
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.rdata_o = rdata_q;
    assign bus.ack_o   = ack_q;
    assign bus.nack_o  = nack_q;
    assign bus.done_o  = done_q;
    assign bus.busy_o  = busy_q;
`ifdef RX_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`endif
endmodule

// File: tb/tb_i2c_rx.sv
// Testbench for i2c_rx: bit-level I2C bus driver with an expected-result queue per transaction.
module tb_i2c_rx;
    localparam int SD = 30;
    localparam int TO = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_rx_if bus_if ();
`ifdef RX_TIMEOUT_EN
    logic timeout;
`endif

    i2c_rx #(.SAMPLE_DLY(SD), .TIMEOUT_CYC(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
`ifdef RX_TIMEOUT_EN
        .timeout_o (timeout),
`endif
        .bus   (bus_if)
    );

    // Expected result word: {timeout, nack, ack[2:0], rdata[7:0]}
    logic [12:0] exp_q[$];
    logic [7:0]  rdata_model = 8'h00;
    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int owned_rise_cyc = 0;

    // Monitor: only this process writes the captured-done variables.
    int          done_cnt = 0;
    logic [12:0] got_last = '0;
    int          lat_last = 0;
    logic        to_bit;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef RX_TIMEOUT_EN
    assign to_bit = timeout;
`else
    assign to_bit = 1'b0;
`endif

    always @(negedge clk) begin
        if (!rst && bus_if.done_o) begin
            done_cnt <= done_cnt + 1;
            got_last <= {to_bit, bus_if.nack_o, bus_if.ack_o, bus_if.rdata_o};
            lat_last <= cyc - owned_rise_cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic rd);
        @(negedge clk);
        bus_if.start_i  = 1'b1;
        bus_if.rxread_i = rd;
        @(negedge clk);
        bus_if.start_i  = 1'b0;
        bus_if.rxread_i = 1'b0;
        bus_if.sda_sel_i = 1'b0;
        bus_if.sda_i    = 1'b0;
        wait_neg(30);
        bus_if.scl_i    = 1'b0;
        wait_neg(30);
    endtask

    task automatic bit_pulse(input logic sda_v, input logic sel_v);
        bus_if.sda_i     = sda_v;
        bus_if.sda_sel_i = sel_v;
        wait_neg(30);
        bus_if.scl_i = 1'b1;
        if (sel_v) owned_rise_cyc = cyc;
        wait_neg(60);
        bus_if.scl_i = 1'b0;
        wait_neg(30);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic slave_sda);
        for (int i = 7; i >= 0; i--) bit_pulse(b[i], 1'b0);
        bit_pulse(slave_sda, 1'b1);
    endtask

    task automatic read_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bit_pulse(b[i], 1'b1);
    endtask

    task automatic rep_start();
        bus_if.sda_sel_i = 1'b0;
        bus_if.sda_i = 1'b1;
        wait_neg(30);
        bus_if.scl_i = 1'b1;
        wait_neg(30);
        bus_if.sda_i = 1'b0;
        wait_neg(30);
        bus_if.scl_i = 1'b0;
        wait_neg(30);
    endtask

    task automatic send_stop();
        bus_if.sda_sel_i = 1'b0;
        bus_if.sda_i = 1'b0;
        wait_neg(30);
        bus_if.scl_i = 1'b1;
        wait_neg(30);
        bus_if.sda_i = 1'b1;
        wait_neg(30);
    endtask

    task automatic glitch_pulse();
        bus_if.sda_i = 1'b1;
        bus_if.sda_sel_i = 1'b1;
        wait_neg(30);
        bus_if.scl_i = 1'b1;
        wait_neg(20);
        bus_if.scl_i = 1'b0;
        wait_neg(30);
    endtask

    // Full transaction; nk holds the slave's SDA level in each of the three ACK slots.
    task automatic run_txn(input logic rd, input logic [7:0] wbyte, input logic [2:0] nk,
                           input logic [7:0] rbyte, input logic glitch);
        do_start(rd);
        send_byte(8'hA0, nk[0]);
        if (glitch) glitch_pulse();
        send_byte(8'h10, nk[1]);
        if (rd) begin
            rep_start();
            send_byte(8'hA1, nk[2]);
            read_byte(rbyte);
            bit_pulse(1'b1, 1'b0);
        end else begin
            send_byte(wbyte, nk[2]);
        end
        send_stop();
        wait_neg(10);
    endtask

    task automatic push_exp(input logic rd, input logic [2:0] nk, input logic [7:0] rbyte);
        logic [2:0] a;
        a = ~nk;
        if (rd) rdata_model = rbyte;
        exp_q.push_back({1'b0, ~&a, a, rdata_model});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tests_run++;
        if ({bus_if.rdata_o, bus_if.ack_o, bus_if.nack_o, bus_if.done_o, bus_if.busy_o} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdata=%h ack=%b nack=%b done=%b busy=%b, want all 0",
                     bus_if.rdata_o, bus_if.ack_o, bus_if.nack_o, bus_if.done_o, bus_if.busy_o);
        end
    endtask

    task automatic test_write_ack();
        int n0;
        logic [12:0] e;
        n0 = done_cnt;
        push_exp(1'b0, 3'b000, 8'h00);
        do_start(1'b0);
        tests_run++;
        if (bus_if.busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_busy_high: busy_o=%b want 1", bus_if.busy_o);
        end
        send_byte(8'hA0, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h55, 1'b0);
        send_stop();
        wait_neg(10);
        e = exp_q.pop_front();
        tests_run += 4;
        if (done_cnt - n0 != 1) begin
            tests_failed++;
            $display("FAIL write_ack_done_count: got %0d want 1", done_cnt - n0);
        end
        if (got_last !== e) begin
            tests_failed++;
            $display("FAIL write_ack_result: got %h want %h", got_last, e);
        end
        if (lat_last != SD + 4) begin
            tests_failed++;
            $display("FAIL write_ack_latency: got %0d want %0d", lat_last, SD + 4);
        end
        if (bus_if.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_busy_low: busy_o=%b want 0", bus_if.busy_o);
        end
    endtask

    task automatic test_write_nack();
        int n0;
        logic [12:0] e;
        n0 = done_cnt;
        push_exp(1'b0, 3'b010, 8'h00);
        do_start(1'b0);
        send_byte(8'hA0, 1'b0);
        // A second start while busy must be ignored.
        @(negedge clk);
        bus_if.start_i = 1'b1;
        bus_if.rxread_i = 1'b1;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        bus_if.rxread_i = 1'b0;
        send_byte(8'h10, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_stop();
        wait_neg(10);
        e = exp_q.pop_front();
        tests_run += 2;
        if (done_cnt - n0 != 1) begin
            tests_failed++;
            $display("FAIL write_nack_done_count: got %0d want 1", done_cnt - n0);
        end
        if (got_last !== e) begin
            tests_failed++;
            $display("FAIL write_nack_result: got %h want %h", got_last, e);
        end
    endtask

    task automatic test_read();
        int n0;
        logic [12:0] e;
        n0 = done_cnt;
        push_exp(1'b1, 3'b000, 8'hC3);
        run_txn(1'b1, 8'h00, 3'b000, 8'hC3, 1'b0);
        e = exp_q.pop_front();
        tests_run += 3;
        if (done_cnt - n0 != 1) begin
            tests_failed++;
            $display("FAIL read_done_count: got %0d want 1", done_cnt - n0);
        end
        if (got_last !== e) begin
            tests_failed++;
            $display("FAIL read_result: got %h want %h", got_last, e);
        end
        if (lat_last != SD + 4) begin
            tests_failed++;
            $display("FAIL read_latency: got %0d want %0d", lat_last, SD + 4);
        end
    endtask

    task automatic test_glitch();
        int n0;
        logic [12:0] e;
        n0 = done_cnt;
        push_exp(1'b0, 3'b000, 8'h00);
        run_txn(1'b0, 8'h77, 3'b000, 8'h00, 1'b1);
        e = exp_q.pop_front();
        tests_run += 2;
        if (done_cnt - n0 != 1) begin
            tests_failed++;
            $display("FAIL glitch_done_count: got %0d want 1", done_cnt - n0);
        end
        if (got_last !== e) begin
            tests_failed++;
            $display("FAIL glitch_result: got %h want %h", got_last, e);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        logic [12:0] e;
        n0 = done_cnt;
        push_exp(1'b1, 3'b000, 8'h96);
        do_start(1'b1);
        send_byte(8'hA0, 1'b0);
        send_byte(8'h10, 1'b0);
        rep_start();
        send_byte(8'hA1, 1'b0);
        for (int i = 0; i < 4; i++) bit_pulse(1'b1, 1'b1);
        bus_if.sda_i = 1'b0;
        wait_neg(30);
        bus_if.scl_i = 1'b1;
        wait_neg(20);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus_if.rdata_o, bus_if.ack_o, bus_if.nack_o, bus_if.done_o, bus_if.busy_o} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got rdata=%h ack=%b nack=%b done=%b busy=%b, want all 0",
                     bus_if.rdata_o, bus_if.ack_o, bus_if.nack_o, bus_if.done_o, bus_if.busy_o);
        end
        wait_neg(3);
        rst = 1'b0;
        exp_q.delete();
        rdata_model = 8'h00;
        wait_neg(40);
        bus_if.scl_i = 1'b0;
        wait_neg(30);
        for (int i = 0; i < 3; i++) bit_pulse(1'b0, 1'b1);
        bit_pulse(1'b1, 1'b0);
        send_stop();
        wait_neg(10);
        tests_run++;
        if (done_cnt != n0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_done: got %0d done pulses want 0", done_cnt - n0);
        end
        n0 = done_cnt;
        push_exp(1'b0, 3'b100, 8'h00);
        run_txn(1'b0, 8'h5A, 3'b100, 8'h00, 1'b0);
        e = exp_q.pop_front();
        tests_run += 2;
        if (done_cnt - n0 != 1) begin
            tests_failed++;
            $display("FAIL reset_mid_restart_count: got %0d want 1", done_cnt - n0);
        end
        if (got_last !== e) begin
            tests_failed++;
            $display("FAIL reset_mid_restart_result: got %h want %h", got_last, e);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        logic rd;
        logic [2:0] nk;
        logic [7:0] d;
        logic [12:0] e;
        for (int i = 0; i < 4; i++) begin
            rd = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            nk = 3'($urandom_range(0, 7));
            d  = 8'($urandom_range(0, 255));
            n0 = done_cnt;
            push_exp(rd, nk, d);
            run_txn(rd, d, nk, d, 1'b0);
            e = exp_q.pop_front();
            tests_run += 3;
            if (done_cnt - n0 != 1) begin
                tests_failed++;
                $display("FAIL b2b_%0d_done_count: got %0d want 1", i, done_cnt - n0);
            end
            if (got_last !== e) begin
                tests_failed++;
                $display("FAIL b2b_%0d_result: rd=%b got %h want %h", i, rd, got_last, e);
            end
            if (lat_last != SD + 4) begin
                tests_failed++;
                $display("FAIL b2b_%0d_latency: got %0d want %0d", i, lat_last, SD + 4);
            end
        end
    endtask

`ifdef RX_TIMEOUT_EN
    task automatic test_timeout();
        int n0;
        logic [12:0] e;
        n0 = done_cnt;
        exp_q.push_back({1'b1, 1'b1, 3'b001, rdata_model});
        do_start(1'b0);
        send_byte(8'hA0, 1'b0);
        wait_neg(TO + 100);
        send_stop();
        wait_neg(10);
        e = exp_q.pop_front();
        tests_run += 2;
        if (done_cnt - n0 != 1) begin
            tests_failed++;
            $display("FAIL timeout_done_count: got %0d want 1", done_cnt - n0);
        end
        if (got_last !== e) begin
            tests_failed++;
            $display("FAIL timeout_result: got %h want %h", got_last, e);
        end
    endtask
`endif

    initial begin
        bus_if.start_i   = 1'b0;
        bus_if.rxread_i  = 1'b0;
        bus_if.scl_i     = 1'b1;
        bus_if.sda_i     = 1'b1;
        bus_if.sda_sel_i = 1'b0;
        wait_neg(3);
        test_reset();
        rst = 1'b0;
        wait_neg(5);
        test_write_ack();
        test_write_nack();
        test_read();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
`ifdef RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
